// File: rtl/simon_sequence_player.sv
// Simon pattern playback: regenerates an LFSR colour sequence from a seed, shows it
// through the LED driver's select/enable inputs, and also provides a timed all-LED strobe.
module simon_sequence_player #(
  parameter int unsigned MILLI_SECOND = 100_000,
  parameter int unsigned ON_TICKS     = 200 * MILLI_SECOND,
  parameter int unsigned OFF_TICKS    = 100 * MILLI_SECOND,
  parameter int unsigned STROBE_TICKS = 500 * MILLI_SECOND,
  parameter int unsigned CNT_W        = 27
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] seed,
  input  logic [5:0]  length,
  input  logic        flash,
  output logic        busy,
  output logic        done,
  output logic [1:0]  select,
  output logic        enable,
  output logic        strobe
);

  typedef enum logic [1:0] {
    IDLE,
    ON,
    OFF,
    FLASH
  } state_t;

  localparam logic [15:0] LFSR_INIT = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  localparam logic [5:0]  MAX_LEN   = 6'd32;

  localparam logic [CNT_W-1:0] ON_LOAD     = CNT_W'(ON_TICKS - 1);
  localparam logic [CNT_W-1:0] OFF_LOAD    = CNT_W'(OFF_TICKS - 1);
  localparam logic [CNT_W-1:0] STROBE_LOAD = CNT_W'(STROBE_TICKS - 1);
  localparam logic [CNT_W-1:0] ONE         = CNT_W'(1);

  state_t           state, state_n;
  logic [15:0]      lfsr, lfsr_n;
  logic [CNT_W-1:0] timer, timer_n;
  logic [5:0]       idx, idx_n;
  logic [5:0]       len, len_n;
  logic [1:0]       select_n;
  logic             done_n;
  logic             timer_zero;

  function automatic logic [15:0] lfsr_step(input logic [15:0] cur);
    return (cur >> 1) ^ (cur[0] ? LFSR_TAPS : 16'h0000);
  endfunction

  assign timer_zero = (timer == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      lfsr   <= LFSR_INIT;
      timer  <= '0;
      idx    <= '0;
      len    <= '0;
      select <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
      enable <= 1'b0;
      strobe <= 1'b0;
    end else begin
      state  <= state_n;
      lfsr   <= lfsr_n;
      timer  <= timer_n;
      idx    <= idx_n;
      len    <= len_n;
      select <= select_n;
      done   <= done_n;
      // Outputs are decoded from the next state so they line up with it exactly.
      busy   <= (state_n != IDLE);
      enable <= (state_n == ON);
      strobe <= (state_n == FLASH);
    end
  end

  always_comb begin
    state_n  = state;
    lfsr_n   = lfsr;
    timer_n  = timer;
    idx_n    = idx;
    len_n    = len;
    select_n = select;
    done_n   = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          if (length != '0) begin
            lfsr_n   = (seed == '0) ? LFSR_INIT : seed;
            len_n    = (length > MAX_LEN) ? MAX_LEN : length;
            idx_n    = '0;
            select_n = lfsr_n[1:0];
            timer_n  = ON_LOAD;
            state_n  = ON;
          end else begin
            done_n = 1'b1;
          end
        end else if (flash) begin
          timer_n = STROBE_LOAD;
          state_n = FLASH;
        end
      end

      ON: begin
        if (timer_zero) begin
          lfsr_n  = lfsr_step(lfsr);
          timer_n = OFF_LOAD;
          state_n = OFF;
        end else begin
          timer_n = timer - ONE;
        end
      end

      OFF: begin
        if (timer_zero) begin
          if (idx == len - 6'd1) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            idx_n    = idx + 6'd1;
            select_n = lfsr[1:0];
            timer_n  = ON_LOAD;
            state_n  = ON;
          end
        end else begin
          timer_n = timer - ONE;
        end
      end

      FLASH: begin
        if (timer_zero) begin
          state_n = IDLE;
        end else begin
          timer_n = timer - ONE;
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule
